mdu_iterative: RTL

Iterative multiply/divide unit for the RV32M instructions, placed in the execute stage next to the ALU. The operands and funct3 come from the ID/EX register. The unit takes a fixed 33 cycles per operation, holds `busy` high so the hazard unit stalls the front of the pipeline, and returns a 32-bit result with a one-cycle `done` pulse. The ALU keeps all RV32I arithmetic; this block handles only MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/mdu_iterative_if.sv | 22 ++
 rtl/mdu_iterative.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// Master drives start/flush/op/a/b; slave returns busy/done/result.
interface mdu_iterative_if;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit, fixed 33-cycle latency.
// Ports: clk, reset (async, active-low), bus (slave: start/flush/op/a/b in; busy/done/result out).
module mdu_iterative (
  input  logic           clk,
  input  logic           reset,
  mdu_iterative_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] opd;
  logic [63:0] acc;
  logic        neg_q;
  logic        neg_r;
  logic        done_q;
  logic [31:0] res_q;

  logic        go;
  logic        is_div;
  logic        sgn_a;
  logic        sgn_b;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign go     = (state == IDLE) & bus.start & ~bus.flush;
  assign is_div = bus.op[2];

  // div/rem are signed when op[0]=0; mulh/mulhsu sign a, only mulh signs b.
  assign sgn_a = is_div ? ~bus.op[0]
                        : (bus.op[1] ^ bus.op[0]);
  assign sgn_b = is_div ? ~bus.op[0]
                        : (bus.op[1:0] == 2'b01);
  assign neg_a = sgn_a & bus.a[31];
  assign neg_b = sgn_b & bus.b[31];
  assign mag_a = neg_a ? -bus.a : bus.a;
  assign mag_b = neg_b ? -bus.b : bus.b;

  // Multiply step: add multiplicand on low bit, shift right.
  logic [32:0] msum;
  logic [63:0] mul_nx;
  assign msum   = {1'b0, acc[63:32]}
                + (acc[0] ? {1'b0, opd} : 33'd0);
  assign mul_nx = {msum, acc[31:1]};

  // Restoring divide step: shift in next dividend bit, try subtract.
  logic [32:0] part;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_nx;
  logic [63:0] div_nx;
  assign part   = acc[63:31];
  assign diff   = part - {1'b0, opd};
  assign ge     = part >= {1'b0, opd};
  assign rem_nx = ge ? diff[31:0] : part[31:0];
  assign div_nx = {rem_nx, acc[30:0], ge};

  // Sign fix-up and result select.
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fin_val;
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[31:0] : acc[31:0];
  assign rem  = neg_r ? -acc[63:32] : acc[63:32];

  always_comb begin
    fin_val = rem;
    unique case (op_q)
      3'b000:                 fin_val = prod[31:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[63:32];
      3'b100, 3'b101:         fin_val = quo;
      default:                fin_val = rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = RUN;
      RUN: begin
        if (bus.flush)
          state_nx = IDLE;
        else if (cnt == 5'd31)
          state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_q   <= '0;
      opd    <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        cnt   <= '0;
        op_q  <= bus.op;
        opd   <= is_div ? mag_b : mag_a;
        acc   <= {32'd0, is_div ? mag_a : mag_b};
        // x/0 keeps an all-ones quotient, so no negation then.
        neg_q <= (neg_a ^ neg_b)
               & (~is_div | (|bus.b));
        neg_r <= neg_a;
      end else if (state == RUN && !bus.flush) begin
        cnt <= cnt + 5'd1;
        acc <= op_q[2] ? div_nx : mul_nx;
      end else if (state == FIN && !bus.flush) begin
        res_q  <= fin_val;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule
